// File: rtl/tc_pkg.sv
// tc_pkg: phase encoding, lamp bit offsets and next-road selection shared by the controller.
package tc_pkg;
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;
  localparam int LAMP_G = 2;
  localparam int LAMP_Y = 1;
  localparam int LAMP_R = 0;
  // First road cyclically after act with demand; plain round-robin step when nobody waits.
  function automatic logic [2:0] next_road(input logic [7:0] t, input logic [2:0] act, input int n);
    logic [2:0] r;
    int idx;
    r = 3'((int'(act) + 1) % n);
    for (int k = n - 1; k >= 1; k--) begin
      idx = (int'(act) + k) % n;
      if (t[idx[2:0]]) r = 3'(idx);
    end
    return r;
  endfunction
endpackage

// File: rtl/tc_phase_timer.sv
// tc_phase_timer: saturating phase tick counter with synchronous clear.
module tc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_cnt
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_cnt <= '0;
    else if (i_clr) o_cnt <= '0;
    else if (i_tick && o_cnt != '1) o_cnt <= o_cnt + 1'b1;
endmodule

// File: rtl/tc_phase_ctrl.sv
// tc_phase_ctrl: N-road Moore traffic-light controller with demand skipping and flashing-yellow mode.
module tc_phase_ctrl
  import tc_pkg::*;
#(
  parameter int N_ROADS   = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                   CLK,
  input  logic                   R_N,
  input  logic                   TICK,
  input  logic [N_ROADS-1:0]     T,
  input  logic                   FLASH,
  output logic [3*N_ROADS-1:0]   L,
  output logic [2:0]             ACTIVE,
  output logic [1:0]             PHASE
);
  localparam logic [CNT_W:0] LP_GMIN = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] LP_GMAX = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] LP_YEL  = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] LP_AR   = (CNT_W+1)'(ALLRED_T);
  phase_t           r_phase;
  logic [2:0]       r_active;
  logic             r_blink;
  logic             r_fx;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W:0]   w_e;
  logic [7:0]       w_t;
  logic             w_other;
  logic             w_go;
  assign w_t     = 8'(T);
  assign w_e     = {1'b0, w_cnt} + 1'b1;
  assign w_other = |(w_t & ~(8'd1 << r_active));
  assign w_go    = TICK && (r_phase == PH_GREEN  ? FLASH || (w_other && ((w_e >= LP_GMIN && !w_t[r_active]) || w_e >= LP_GMAX)) :
                            r_phase == PH_YELLOW ? w_e == LP_YEL :
                            r_phase == PH_ALLRED ? w_e == LP_AR : !FLASH);
  tc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (CLK),
    .i_rst_n (R_N),
    .i_clr   (w_go),
    .i_tick  (TICK),
    .o_cnt   (w_cnt)
  );
  // r_fx remembers a maintenance episode so the following green restarts at road 0.
  always_ff @(posedge CLK or negedge R_N)
    if (!R_N) begin
      r_phase  <= PH_GREEN;
      r_active <= 3'd0;
      r_blink  <= 1'b0;
      r_fx     <= 1'b0;
    end else begin
      case (r_phase)
        PH_GREEN:  if (w_go) r_phase <= PH_YELLOW;
        PH_YELLOW: if (w_go) r_phase <= PH_ALLRED;
        PH_ALLRED: if (w_go) begin
          r_phase  <= FLASH ? PH_FLASH : PH_GREEN;
          r_fx     <= FLASH;
          r_active <= FLASH ? r_active : r_fx ? 3'd0 : next_road(w_t, r_active, N_ROADS);
        end
        PH_FLASH:  if (TICK) begin
          r_blink <= FLASH && !r_blink;
          r_phase <= FLASH ? PH_FLASH : PH_ALLRED;
        end
      endcase
    end
  assign ACTIVE = r_active;
  assign PHASE  = r_phase;
  for (genvar g = 0; g < N_ROADS; g++) begin : g_lamp
    logic w_act;
    assign w_act             = r_active == 3'(g);
    assign L[3*g+LAMP_G]     = w_act && r_phase == PH_GREEN;
    assign L[3*g+LAMP_Y]     = r_phase == PH_FLASH ? r_blink : w_act && r_phase == PH_YELLOW;
    assign L[3*g+LAMP_R]     = r_phase != PH_FLASH && !(w_act && (r_phase == PH_GREEN || r_phase == PH_YELLOW));
  end
endmodule

// File: doc/tc_phase_ctrl.md
# tc_phase_ctrl

Parametrised N-road Moore traffic-light controller with tick-based phase timing. It runs a green/yellow/all-red cycle per road and skips roads with no demand. It adds minimum/maximum green, an all-red clearance interval and a flashing-yellow maintenance mode. It sits at the top of the intersection datapath, driven by a prescaled timebase strobe and the road sensors, and it drives the lamp outputs directly.

## Interface
- N_ROADS, 2: number of roads, 2..8
- CNT_W, 8: phase timer width
- GREEN_MIN, 4: minimum green, in ticks
- GREEN_MAX, 16: maximum green while another road has demand, in ticks
- YELLOW_T, 2: yellow duration, in ticks
- ALLRED_T, 1: all-red clearance, in ticks
- Constraints: 1 ≤ GREEN_MIN ≤ GREEN_MAX < 2^CNT_W; YELLOW_T, ALLRED_T ≥ 1 and < 2^CNT_W

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge
- R_N  in  1  asynchronous, active-low reset
- TICK  in  1  timebase strobe, one CLK wide; timers advance only on TICK
- T  in  N_ROADS  traffic sensors; T[i]=1 means road i has demand
- FLASH  in  1  maintenance flashing request, level
- L  out  3*N_ROADS  lamps; road i uses L[3i+2] green, L[3i+1] yellow, L[3i] red
- ACTIVE  out  3  index of the current or last-served road
- PHASE  out  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=FLASH

## Operation
- Reset: PHASE=GREEN, ACTIVE=0, timer=0, blink=0. Road 0 shows green and all other roads show red.
- The timer clears on every phase entry and increments on TICK, saturating at 2^CNT_W−1. Let e = timer+1 on a TICK cycle.
- other = OR of T[j] for all j≠ACTIVE.
- GREEN, on TICK:
  - FLASH=1 → YELLOW.
  - Otherwise, if other and ((e ≥ GREEN_MIN and !T[ACTIVE]) or e ≥ GREEN_MAX) → YELLOW.
  - Otherwise stay in GREEN. With no other demand, green holds indefinitely.
- YELLOW, on TICK with e = YELLOW_T → ALLRED.
- ALLRED, on TICK with e = ALLRED_T:
  - FLASH=1 → FLASH.
  - Otherwise → GREEN. ACTIVE becomes the first j cyclically after ACTIVE with T[j]=1; if there is none, ACTIVE+1 mod N_ROADS.
  - After leaving FLASH, ACTIVE becomes 0.
- FLASH: blink toggles on each TICK. Every road shows yellow=blink, green=0, red=0. FLASH=0 sampled on a TICK → ALLRED (blink cleared), then GREEN on road 0.
- Lamp decode:
  - ACTIVE road: green in GREEN, yellow in YELLOW, red in ALLRED.
  - Other roads: red in GREEN, YELLOW and ALLRED.
  - No road ever has green together with another road's green or yellow.
- FLASH arriving during YELLOW or ALLRED does not shorten the phase; it takes effect at the ALLRED exit.

## Timing
- L, ACTIVE and PHASE are decoded from registered state only, so they are glitch-free.
- Phase changes take effect on the CLK edge that samples the qualifying TICK. Lamps reflect the change in the same cycle as the new state.
- T and FLASH are sampled only on TICK cycles. Changes between ticks have no effect.
- R_N low at any time, including mid-YELLOW or mid-FLASH, immediately forces the reset values. Operation resumes on the first TICK after R_N rises.
- With TICK held high, a non-extended green-to-green handover takes YELLOW_T+ALLRED_T cycles.

## Structure
- Package tc_pkg holds:
  - the phase encoding constants (GREEN/YELLOW/ALLRED/FLASH)
  - the lamp bit offsets (green=2, yellow=1, red=0)
  - a function computing the next active road from T and ACTIVE
- Sub-module tc_phase_timer: CNT_W-bit saturating counter with clear and TICK enable. It outputs the count; the FSM compares it against the parameters.

## Test plan
The bench uses N_ROADS=3, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, and TICK=1 every cycle unless stated otherwise.
1. Reset, T=3'b000 → L=9'b001_001_100, PHASE=0, ACTIVE=0. The outputs hold for 20 ticks.
2. T=3'b010 after reset → 4 ticks GREEN, 2 ticks YELLOW (L[1]=1), 1 tick ALLRED (L=9'b001_001_001), then ACTIVE=1 with L=9'b001_100_001.
3. T=3'b111 held → every green lasts 8 ticks, and ACTIVE sequences 0,1,2,0.
4. T=3'b101 with ACTIVE=0 → after GREEN_MAX, road 1 is skipped and ACTIVE=2.
5. TICK asserted every 4th cycle, T=3'b010 → GREEN lasts 16 cycles. Toggling T between ticks has no effect.
6. FLASH=1 at tick 2 of green → YELLOW, then ALLRED, then FLASH with L=9'b010_010_010 and 9'b000_000_000 alternating each tick. FLASH=0 → 1 ALLRED tick, then road 0 green. R_N pulsed low mid-FLASH → reset values in the same cycle.
